// File: rtl/fir_coef_loader.sv
// -----------------------------------------------------------------------------
// fir_coef_loader
//
// Front-end for the 11-tap FIR. Coefficient words arrive one at a time over a
// valid/ready handshake and are collected in a shadow bank. Once all NTAPS
// words are in, the whole bank is copied to the active outputs on one edge.
// As a result, the filter never sees a partially written coefficient set.
// The sample stream is registered on its way to the filter. It is only
// flagged valid once a complete set has been committed since reset.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   ld_start  one-cycle request to begin (or restart) a coefficient load
//   ld_valid  ld_data holds a coefficient word
//   ld_data   coefficient word (two's complement), b0 first
//   ld_ready  loader accepts a word this cycle
//   ld_err    one-cycle pulse: a load in progress was restarted
//   coef_ok   a full coefficient set has been committed since reset
//   sin/svin  input sample and its valid
//   dout/vout registered sample and valid towards the filter
//   b0..b10   active coefficients (port list is fixed at eleven taps)
// -----------------------------------------------------------------------------
module fir_coef_loader #(
   parameter int NB    = 8,
   parameter int NTAPS = 11
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ld_start,
   input  logic          ld_valid,
   input  logic [NB-1:0] ld_data,
   output logic          ld_ready,
   output logic          ld_err,
   output logic          coef_ok,
   input  logic [NB-1:0] sin,
   input  logic          svin,
   output logic [NB-1:0] dout,
   output logic          vout,
   output logic [NB-1:0] b0,
   output logic [NB-1:0] b1,
   output logic [NB-1:0] b2,
   output logic [NB-1:0] b3,
   output logic [NB-1:0] b4,
   output logic [NB-1:0] b5,
   output logic [NB-1:0] b6,
   output logic [NB-1:0] b7,
   output logic [NB-1:0] b8,
   output logic [NB-1:0] b9,
   output logic [NB-1:0] b10
);

   localparam int CW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(NTAPS - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t                     state_reg, state_next;
   logic [CW-1:0]              cnt_reg, cnt_next;
   logic [NTAPS-1:0][NB-1:0]   shadow_reg;
   logic [NTAPS-1:0][NB-1:0]   active_reg;
   logic                       ld_err_reg;
   logic                       coef_ok_reg;
   logic [NB-1:0]              dout_reg;
   logic                       vout_reg;
   logic                       wr_en;
   logic                       restart;
   logic                       commit;

   // Next-state logic. A restart has priority over a word presented in the
   // same cycle, so that word is dropped.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      wr_en      = 1'b0;
      restart    = 1'b0;
      commit     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (ld_start) begin
               state_next = LOAD;
               cnt_next   = '0;
            end
         end
         LOAD: begin
            if (ld_start) begin
               restart  = 1'b1;
               cnt_next = '0;
            end else if (ld_valid) begin
               wr_en = 1'b1;
               if (cnt_reg == LAST_IDX) begin
                  // The counter wraps here so it never exceeds NTAPS-1.
                  state_next = COMMIT;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
         end
         COMMIT: begin
            commit     = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         ld_err_reg  <= 1'b0;
         coef_ok_reg <= 1'b0;
         shadow_reg  <= '0;
         active_reg  <= '0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         ld_err_reg <= restart;
         if (wr_en) begin
            shadow_reg[cnt_reg] <= ld_data;
         end
         if (commit) begin
            active_reg  <= shadow_reg;
            coef_ok_reg <= 1'b1;
         end
      end
   end

   // Sample path. vout uses coef_ok from before the edge, so a sample taken
   // at the commit edge itself is still dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_reg <= '0;
         vout_reg <= 1'b0;
      end else begin
         if (svin) begin
            dout_reg <= sin;
         end
         vout_reg <= svin & coef_ok_reg;
      end
   end

   // Decoding ld_ready from the state gives it a zero value during reset.
   // It also rises in the first cycle after ld_start without extra delay.
   assign ld_ready = (state_reg == LOAD);
   assign ld_err   = ld_err_reg;
   assign coef_ok  = coef_ok_reg;
   assign dout     = dout_reg;
   assign vout     = vout_reg;

   assign b0  = active_reg[0];
   assign b1  = active_reg[1];
   assign b2  = active_reg[2];
   assign b3  = active_reg[3];
   assign b4  = active_reg[4];
   assign b5  = active_reg[5];
   assign b6  = active_reg[6];
   assign b7  = active_reg[7];
   assign b8  = active_reg[8];
   assign b9  = active_reg[9];
   assign b10 = active_reg[10];

endmodule
